// File: rtl/uart_rx_frame.sv
// UART receive framer: 2-flop synchronized line, mid-bit sampling, optional parity,
// one-entry holding register with valid/ack handshake and framing/parity/overrun pulses.
module uart_rx_frame #(
    parameter int BIT_CLKS   = 16,
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_REC_dataH,
    output logic [DATA_BITS-1:0] rec_dataH,
    output logic                 rec_validH,
    input  logic                 rec_ackH,
    output logic                 frame_errH,
    output logic                 parity_errH,
    output logic                 overrun_errH
);
    // state      | meaning
    // IDLE       | line idle, waiting for a low level
    // START      | half-bit wait, confirm start bit still low
    // DATA       | sample DATA_BITS data bits, LSB first
    // PARITY     | sample parity bit and note a mismatch
    // STOP       | sample stop bit, deliver or flag the frame
    // BREAK_WAIT | line held low after a framing error
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CLKS - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

    state_t               state;
    logic [1:0]           sync;
    logic [CW-1:0]        bit_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 rxs;

    assign rxs = sync[1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            sync         <= 2'b11;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            par_bad      <= 1'b0;
            rec_dataH    <= '0;
            rec_validH   <= 1'b0;
            frame_errH   <= 1'b0;
            parity_errH  <= 1'b0;
            overrun_errH <= 1'b0;
        end else begin
            sync         <= {sync[0], uart_REC_dataH};
            frame_errH   <= 1'b0;
            parity_errH  <= 1'b0;
            overrun_errH <= 1'b0;
            if (rec_validH && rec_ackH)
                rec_validH <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        bit_cnt <= HALF_LOAD;
                    end
                end
                START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (!rxs) begin
                        state   <= DATA;
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        bit_cnt <= FULL_LOAD;
                        if (bit_idx == LAST_IDX)
                            state <= PARITY_EN ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        par_bad <= (rxs != ((^shift) ^ PARITY_ODD));
                        bit_cnt <= FULL_LOAD;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (!rxs) begin
                        // framing error takes precedence over a parity mismatch
                        frame_errH <= 1'b1;
                        state      <= BREAK_WAIT;
                    end else if (par_bad) begin
                        parity_errH <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= IDLE;
                        if (!rec_validH || rec_ackH) begin
                            rec_dataH  <= shift;
                            rec_validH <= 1'b1;
                        end else begin
                            overrun_errH <= 1'b1;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 instance and an 8E1 instance, each compared every
// cycle against a frame-level timing model built from the line protocol rules.
module tb_uart_rx_frame;
    localparam int EV_DEL = 0;
    localparam int EV_FRM = 1;
    localparam int EV_PAR = 2;

    typedef struct {
        int         cyc;
        int         u;
        int         kind;
        logic [7:0] d;
    } ev_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       line0, line1, ack0, ack1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, ferr0, ferr1, perr0, perr1, oerr0, oerr1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    int   n_ferr0 = 0, n_oerr0 = 0, n_perr1 = 0;
    ev_t  evq[$];

    logic [7:0] exp_data[2];
    logic       exp_valid[2], exp_ferr[2], exp_perr[2], exp_oerr[2];
    logic       m_ack, m_dl;
    logic [7:0] m_dd;

    always #5 sys_clk = ~sys_clk;

    uart_rx_frame #(.BIT_CLKS(16), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_REC_dataH(line0),
        .rec_dataH(data0), .rec_validH(valid0), .rec_ackH(ack0),
        .frame_errH(ferr0), .parity_errH(perr0), .overrun_errH(oerr0));

    uart_rx_frame #(.BIT_CLKS(16), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_REC_dataH(line1),
        .rec_dataH(data1), .rec_validH(valid1), .rec_ackH(ack1),
        .frame_errH(ferr1), .parity_errH(perr1), .overrun_errH(oerr1));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model: each frame becomes one outcome event at its stop-sample edge;
    // the holding register follows the handshake rules.
    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (sys_rst) begin
            armed = 1'b1;
            evq.delete();
            for (int u = 0; u < 2; u++) begin
                exp_data[u] = 8'h00; exp_valid[u] = 1'b0;
                exp_ferr[u] = 1'b0; exp_perr[u] = 1'b0; exp_oerr[u] = 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_ack = (u == 0) ? ack0 : ack1;
                m_dl = 1'b0;
                m_dd = 8'h00;
                exp_ferr[u] = 1'b0; exp_perr[u] = 1'b0; exp_oerr[u] = 1'b0;
                for (int i = 0; i < evq.size(); i++) begin
                    if (evq[i].cyc == cyc && evq[i].u == u) begin
                        if (evq[i].kind == EV_FRM) exp_ferr[u] = 1'b1;
                        else if (evq[i].kind == EV_PAR) exp_perr[u] = 1'b1;
                        else begin m_dl = 1'b1; m_dd = evq[i].d; end
                    end
                end
                if (m_dl) begin
                    if (!exp_valid[u] || m_ack) begin
                        exp_data[u] = m_dd;
                        exp_valid[u] = 1'b1;
                    end else begin
                        exp_oerr[u] = 1'b1;
                    end
                end else if (exp_valid[u] && m_ack) begin
                    exp_valid[u] = 1'b0;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (armed) begin
            chk("valid0", valid0, exp_valid[0]);
            chk("data0",  data0,  exp_data[0]);
            chk("ferr0",  ferr0,  exp_ferr[0]);
            chk("perr0",  perr0,  exp_perr[0]);
            chk("oerr0",  oerr0,  exp_oerr[0]);
            chk("valid1", valid1, exp_valid[1]);
            chk("data1",  data1,  exp_data[1]);
            chk("ferr1",  ferr1,  exp_ferr[1]);
            chk("perr1",  perr1,  exp_perr[1]);
            chk("oerr1",  oerr1,  exp_oerr[1]);
            n_ferr0 += int'(ferr0);
            n_oerr0 += int'(oerr0);
            n_perr1 += int'(perr1);
        end
    end

    task automatic drive(input int u, input logic v, input int n);
        if (u == 0) line0 = v; else line1 = v;
        repeat (n) @(negedge sys_clk);
    endtask

    // Called at a negedge. Stop sample lands 10 clocks after the first low-sampling
    // edge k (2 sync + 8 half-bit) plus 16 per bit before the stop bit.
    task automatic send(input int u, input logic [7:0] d, input logic stop_v,
                        input int stop_len, input logic par_v);
        int k, nstop, kind;
        bit par_en;
        par_en = (u == 1);
        k = cyc + 1;
        nstop = par_en ? 10 : 9;
        if (!stop_v) kind = EV_FRM;
        else if (par_en && (par_v != ^d)) kind = EV_PAR;
        else kind = EV_DEL;
        evq.push_back('{k + 10 + 16 * nstop, u, kind, d});
        drive(u, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(u, d[i], 16);
        if (par_en) drive(u, par_v, 16);
        drive(u, stop_v, stop_len);
        drive(u, 1'b1, 24);
    endtask

    task automatic ack_pulse(input int u);
        if (u == 0) ack0 = 1'b1; else ack1 = 1'b1;
        @(negedge sys_clk);
        if (u == 0) ack0 = 1'b0; else ack1 = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic ack_at(input int u, input int target);
        while (cyc < target - 1) @(negedge sys_clk);
        if (u == 0) ack0 = 1'b1; else ack1 = 1'b1;
        @(negedge sys_clk);
        if (u == 0) ack0 = 1'b0; else ack1 = 1'b0;
    endtask

    initial begin
        repeat (20000) @(posedge sys_clk);
        $display("FAIL timeout: bench did not complete within cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        int kk, n0;
        sys_rst = 1'b1; line0 = 1'b1; line1 = 1'b1; ack0 = 1'b0; ack1 = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rst_valid0", valid0, 1'b0);
        chk("rst_data0", data0, 8'h00);
        repeat (5) @(negedge sys_clk);

        // 1: plain 8N1 byte, then ack
        send(0, 8'hA5, 1'b1, 16, 1'b0);
        chk("t1_data", data0, 8'hA5);
        chk("t1_valid", valid0, 1'b1);
        ack0 = 1'b1;
        @(negedge sys_clk);
        ack0 = 1'b0;
        chk("t1_ack_clear", valid0, 1'b0);
        chk("t1_data_hold", data0, 8'hA5);

        // 2: short low glitch
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 40);
        chk("t2_valid", valid0, 1'b0);
        chk("t2_no_ferr", 8'(n_ferr0), 8'd0);

        // 3: stop bit held low, then a good byte
        n0 = n_ferr0;
        send(0, 8'h3C, 1'b0, 40, 1'b0);
        chk("t3_ferr_count", 8'(n_ferr0 - n0), 8'd1);
        chk("t3_valid", valid0, 1'b0);
        send(0, 8'h11, 1'b1, 16, 1'b0);
        chk("t3_next_data", data0, 8'h11);
        chk("t3_next_valid", valid0, 1'b1);
        ack_pulse(0);

        // 4: overrun without ack, then deliver with ack on the same edge
        n0 = n_oerr0;
        send(0, 8'h01, 1'b1, 16, 1'b0);
        send(0, 8'h02, 1'b1, 16, 1'b0);
        chk("t4_oerr_count", 8'(n_oerr0 - n0), 8'd1);
        chk("t4_data_kept", data0, 8'h01);
        ack_pulse(0);
        send(0, 8'h01, 1'b1, 16, 1'b0);
        n0 = n_oerr0;
        kk = cyc + 1;
        fork
            send(0, 8'h02, 1'b1, 16, 1'b0);
            ack_at(0, kk + 154);
        join
        chk("t4_ack_data", data0, 8'h02);
        chk("t4_ack_valid", valid0, 1'b1);
        chk("t4_no_oerr", 8'(n_oerr0 - n0), 8'd0);
        ack_pulse(0);

        // 5: even parity instance
        n0 = n_perr1;
        send(1, 8'h01, 1'b1, 16, 1'b0);
        chk("t5_perr_count", 8'(n_perr1 - n0), 8'd1);
        chk("t5_no_valid", valid1, 1'b0);
        send(1, 8'h01, 1'b1, 16, 1'b1);
        chk("t5_data", data1, 8'h01);
        chk("t5_valid", valid1, 1'b1);

        // 6: reset in the middle of data bit 4, with a word still held
        send(0, 8'h77, 1'b1, 16, 1'b0);
        drive(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(0, 1'b0 ^ kk[0] ^ kk[0] ^ ((8'h5A >> i) & 8'h01) != 0, 16);
        drive(0, 1'b1, 8);
        sys_rst = 1'b1;
        line0 = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("t6_rst_valid0", valid0, 1'b0);
        chk("t6_rst_data0", data0, 8'h00);
        chk("t6_rst_valid1", valid1, 1'b0);
        repeat (20) @(negedge sys_clk);
        send(0, 8'h5A, 1'b1, 16, 1'b0);
        chk("t6_data", data0, 8'h5A);
        chk("t6_valid", valid0, 1'b1);
        ack_pulse(0);
        repeat (5) @(negedge sys_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
